dht_reader: RTL and testbench

Parametrised single-wire reader for DHT11/DHT22-class humidity and temperature sensors. It generates the host start pulse on an open-drain bus and measures the sensor response and 40 data bits in microseconds, not raw clock cycles. It verifies the checksum and presents the latched result with status to the system logic. It replaces the fixed-frequency, one-shot reader, adding timeout detection, checksum checking, re-triggering and optional periodic polling.

---
 rtl/dht_pkg.sv | 30 +++
 rtl/dht_reader_if.sv | 26 ++
 rtl/dht_us_tick.sv | 31 +++
 rtl/dht_reader.sv | 175 +++++++++++++++++
 tb/tb_dht_reader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared state, status codes and frame helpers for the DHT reader
package dht_pkg;

   localparam int US_W = 15;

   typedef enum logic [2:0] {
      IDLE,
      HOST_LOW,
      WAIT_RESP,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      CHECK
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_TIMEOUT = 2'b01,
      ERR_CRC     = 2'b10
   } err_t;

   // Byte 4 is the 8-bit sum of bytes 0..3; bytes are packed MSB first.
   function automatic logic frame_ok(input logic [39:0] f);
      logic [7:0] sum;
      sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return sum == f[7:0];
   endfunction

endpackage

// File: rtl/dht_reader_if.sv
// rtl/dht_reader_if.sv - control and result bundle between system logic and the DHT reader
interface dht_reader_if;
   import dht_pkg::*;

   logic       EN;
   logic       START;
   logic [7:0] HUM_INT;
   logic [7:0] HUM_FLOAT;
   logic [7:0] TEMP_INT;
   logic [7:0] TEMP_FLOAT;
   logic [7:0] CRC;
   logic       VALID;
   logic       BUSY;
   logic [1:0] ERR;

   modport master (
      output EN, START,
      input  HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC, VALID, BUSY, ERR
   );

   modport slave (
      input  EN, START,
      output HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC, VALID, BUSY, ERR
   );

endinterface

// File: rtl/dht_us_tick.sv
// rtl/dht_us_tick.sv - prescaler producing a one-cycle tick every DIV clocks
// A clear restarts the period so the first tick lands exactly DIV clocks later.
module dht_us_tick
   import dht_pkg::*;
#(
   parameter int unsigned DIV = 100
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/dht_reader.sv
// rtl/dht_reader.sv - DHT11/DHT22 single-wire reader with timeout, checksum and status
// Define DHT_AUTOPOLL_EN to add a periodic conversion request every POLL_MS.
module dht_reader
   import dht_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 100_000_000,
   parameter int unsigned START_LOW_US  = 18000,
   parameter int unsigned BIT_THRESH_US = 50,
   parameter int unsigned TIMEOUT_US    = 200,
   parameter int unsigned POLL_MS       = 2000
) (
   input  logic        CLK,
   input  logic        RST,
   dht_reader_if.slave bus,
   inout  wire         DHT_DATA
);

   localparam int unsigned      DIV       = CLK_HZ / 1_000_000;
   localparam logic [US_W-1:0]  US_MAX    = '1;
   localparam logic [US_W-1:0]  START_LEN = US_W'(START_LOW_US);
   localparam logic [US_W-1:0]  THRESH    = US_W'(BIT_THRESH_US);
   localparam logic [US_W-1:0]  TO_LEN    = US_W'(TIMEOUT_US);

   state_t          state, state_next;
   logic            data_s1, data_s2, data_prev, data_fall;
   logic            drive_low;
   logic            us_tick, state_chg;
   logic [US_W-1:0] us_cnt;
   logic [5:0]      bit_idx;
   logic [39:0]     shreg;
   logic            poll_req, timeout_hit, timed_out, sample_bit, load_idx;

   assign DHT_DATA = drive_low ? 1'b0 : 1'bz;

   always_ff @(posedge CLK) begin
      if (RST) begin
         data_s1   <= 1'b1;
         data_s2   <= 1'b1;
         data_prev <= 1'b1;
      end else begin
         data_s1   <= DHT_DATA;
         data_s2   <= data_s1;
         data_prev <= data_s2;
      end
   end

   // The response is recognised on a falling edge so the synchroniser still
   // echoing our own start pulse is not mistaken for the sensor.
   assign data_fall = data_prev & ~data_s2;

`ifdef DHT_AUTOPOLL_EN
   localparam int unsigned POLL_CYCLES = (CLK_HZ / 1000) * POLL_MS;

   logic [31:0] poll_cnt;

   always_ff @(posedge CLK) begin
      if (RST || !bus.EN) begin
         poll_cnt <= '0;
         poll_req <= 1'b0;
      end else if (poll_cnt == 32'(POLL_CYCLES - 1)) begin
         poll_cnt <= '0;
         poll_req <= 1'b1;
      end else begin
         poll_cnt <= poll_cnt + 32'd1;
         poll_req <= 1'b0;
      end
   end
`else
   wire unused_poll_ms;
   assign unused_poll_ms = ^POLL_MS;
   assign poll_req       = 1'b0;
`endif

   dht_us_tick #(.DIV(DIV)) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (state_chg),
      .tick (us_tick)
   );

   assign timeout_hit = (state inside {WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH})
                        && (us_cnt >= TO_LEN);

   always_comb begin
      state_next = state;
      timed_out  = 1'b0;
      sample_bit = 1'b0;
      load_idx   = 1'b0;
      if (!bus.EN) begin
         state_next = IDLE;
      end else if (timeout_hit) begin
         state_next = IDLE;
         timed_out  = 1'b1;
      end else begin
         case (state)
            IDLE:      if (bus.START || poll_req) state_next = HOST_LOW;
            HOST_LOW:  if (us_cnt >= START_LEN)   state_next = WAIT_RESP;
            WAIT_RESP: if (data_fall)             state_next = RESP_LOW;
            RESP_LOW:  if (data_s2)               state_next = RESP_HIGH;
            RESP_HIGH: if (!data_s2) begin
               state_next = BIT_LOW;
               load_idx   = 1'b1;
            end
            BIT_LOW:   if (data_s2)               state_next = BIT_HIGH;
            BIT_HIGH:  if (!data_s2) begin
               sample_bit = 1'b1;
               state_next = (bit_idx == 6'd0) ? CHECK : BIT_LOW;
            end
            CHECK:     state_next = IDLE;
            default:   state_next = IDLE;
         endcase
      end
   end

   assign state_chg = (state_next != state);
   assign bus.BUSY  = (state != IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         drive_low <= 1'b0;
      end else begin
         state     <= state_next;
         drive_low <= (state_next == HOST_LOW);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         us_cnt         <= '0;
         bit_idx        <= '0;
         shreg          <= '0;
         bus.HUM_INT    <= '0;
         bus.HUM_FLOAT  <= '0;
         bus.TEMP_INT   <= '0;
         bus.TEMP_FLOAT <= '0;
         bus.CRC        <= '0;
         bus.VALID      <= 1'b0;
         bus.ERR        <= ERR_OK;
      end else begin
         bus.VALID <= 1'b0;

         if (state_chg)
            us_cnt <= '0;
         else if (us_tick && us_cnt != US_MAX)
            us_cnt <= us_cnt + US_W'(1);

         if (load_idx)
            bit_idx <= 6'd39;
         else if (sample_bit && bit_idx != 6'd0)
            bit_idx <= bit_idx - 6'd1;

         if (sample_bit)
            shreg <= {shreg[38:0], (us_cnt > THRESH)};

         if (timed_out)
            bus.ERR <= ERR_TIMEOUT;

         if (state == CHECK && bus.EN) begin
            if (frame_ok(shreg)) begin
               bus.HUM_INT    <= shreg[39:32];
               bus.HUM_FLOAT  <= shreg[31:24];
               bus.TEMP_INT   <= shreg[23:16];
               bus.TEMP_FLOAT <= shreg[15:8];
               bus.CRC        <= shreg[7:0];
               bus.VALID      <= 1'b1;
               bus.ERR        <= ERR_OK;
            end else begin
               bus.ERR <= ERR_CRC;
            end
         end
      end
   end

endmodule

// File: tb/tb_dht_reader.sv
// tb/tb_dht_reader.sv - self-checking bench for dht_reader with a behavioural sensor
module tb_dht_reader;

   localparam int unsigned CLK_HZ        = 2_000_000;
   localparam int unsigned START_LOW_US  = 100;
   localparam int unsigned BIT_THRESH_US = 50;
   localparam int unsigned TIMEOUT_US    = 200;
   localparam int unsigned POLL_MS       = 1;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   wire  dht_data;
   logic sensor_low = 1'b0;

   assign dht_data = sensor_low ? 1'b0 : 1'bz;
   pullup (dht_data);

   dht_reader_if bus_if ();

   dht_reader #(
      .CLK_HZ        (CLK_HZ),
      .START_LOW_US  (START_LOW_US),
      .BIT_THRESH_US (BIT_THRESH_US),
      .TIMEOUT_US    (TIMEOUT_US),
      .POLL_MS       (POLL_MS)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .bus      (bus_if),
      .DHT_DATA (dht_data)
   );

   always #250ns CLK = ~CLK;

   int          tests = 0;
   int          fails = 0;
   int          valid_count = 0;
   logic [39:0] committed = '0;
   logic [39:0] pending = '0;
   bit          pending_valid = 1'b0;
   logic [39:0] tx_frame = '0;
   bit          sensor_present = 1'b1;
   bit          sensor_active = 1'b0;
   bit          sensor_high = 1'b0;
   int          sensor_bit = -1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      tests++;
      if (got < lo || got > hi) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   function automatic bit frame_good(input logic [39:0] f);
      int s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return (s % 256) == int'(f[7:0]);
   endfunction

   // Sensor: answers a host low of at least 50 us, sends 40 bits MSB first.
   task automatic sensor_model();
      realtime t0;
      forever begin
         @(negedge dht_data);
         t0 = $realtime;
         @(posedge dht_data);
         if (sensor_present && ($realtime - t0) >= 50us) begin
            sensor_active = 1'b1;
            if (frame_good(tx_frame)) begin
               pending       = tx_frame;
               pending_valid = 1'b1;
            end
            #20us sensor_low = 1'b1;
            #80us sensor_low = 1'b0;
            #80us;
            for (int i = 39; i >= 0; i--) begin
               sensor_bit = i;
               sensor_low = 1'b1;
               #50us;
               sensor_low  = 1'b0;
               sensor_high = 1'b1;
               if (tx_frame[i]) #70us;
               else             #30us;
               sensor_high = 1'b0;
            end
            sensor_low = 1'b1;
            #50us sensor_low = 1'b0;
            sensor_bit    = -1;
            sensor_active = 1'b0;
         end
      end
   endtask

   // Outputs may only change together with VALID, and only to a frame the sensor sent with a good sum.
   task automatic compare_loop();
      logic [39:0] got;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            got = {bus_if.HUM_INT, bus_if.HUM_FLOAT, bus_if.TEMP_INT, bus_if.TEMP_FLOAT, bus_if.CRC};
            if (bus_if.VALID) begin
               valid_count++;
               check("valid_expected", 64'(pending_valid), 64'd1);
               check("latched_frame", 64'(got), 64'(pending));
               committed     = pending;
               pending_valid = 1'b0;
            end else begin
               check("held_frame", 64'(got), 64'(committed));
            end
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      bus_if.START = 1'b1;
      @(negedge CLK);
      bus_if.START = 1'b0;
   endtask

   task automatic wait_sensor_idle();
      int n = 0;
      while (sensor_active && n < 20000) begin
         @(negedge CLK);
         n++;
      end
      check("sensor_idle", 64'(sensor_active), 64'd0);
   endtask

   task automatic wait_busy_low(input int maxc);
      int n = 0;
      while (bus_if.BUSY && n < maxc) begin
         @(negedge CLK);
         n++;
      end
      check("txn_done", 64'(bus_if.BUSY), 64'd0);
   endtask

   task automatic run_frame(input logic [39:0] f, input bit inject_start);
      tx_frame       = f;
      sensor_present = 1'b1;
      wait_sensor_idle();
      pulse_start();
      check("busy_after_start", 64'(bus_if.BUSY), 64'd1);
      if (inject_start) begin
         repeat (2000) @(negedge CLK);
         pulse_start();
         check("busy_through_start", 64'(bus_if.BUSY), 64'd1);
      end
      wait_busy_low(12000);
      repeat (2) @(negedge CLK);
   endtask

   task automatic check_bytes(input logic [39:0] exp);
      check("hum_int",    64'(bus_if.HUM_INT),    64'(exp[39:32]));
      check("hum_float",  64'(bus_if.HUM_FLOAT),  64'(exp[31:24]));
      check("temp_int",   64'(bus_if.TEMP_INT),   64'(exp[23:16]));
      check("temp_float", 64'(bus_if.TEMP_FLOAT), 64'(exp[15:8]));
      check("crc",        64'(bus_if.CRC),        64'(exp[7:0]));
   endtask

   initial begin
      int n_low, n_rel, n, rises;
      bit prev_busy;

      bus_if.EN    = 1'b1;
      bus_if.START = 1'b0;
      fork
         sensor_model();
         compare_loop();
      join_none

      repeat (4) @(negedge CLK);
      check_bytes(40'h0);
      check("reset_valid", 64'(bus_if.VALID), 64'd0);
      check("reset_busy",  64'(bus_if.BUSY),  64'd0);
      check("reset_err",   64'(bus_if.ERR),   64'd0);
      check("reset_bus",   64'(dht_data),     64'd1);
      RST = 1'b0;
      repeat (4) @(negedge CLK);

`ifdef DHT_AUTOPOLL_EN
      sensor_present = 1'b0;
      bus_if.EN      = 1'b0;
      @(negedge CLK);
      bus_if.EN = 1'b1;
      rises     = 0;
      prev_busy = 1'b0;
      repeat (7000) begin
         @(negedge CLK);
         if (bus_if.BUSY && !prev_busy) rises++;
         prev_busy = bus_if.BUSY;
      end
      check("poll_conversions", 64'(rises), 64'd3);
      wait_busy_low(2000);
      check("poll_err_timeout", 64'(bus_if.ERR), 64'd1);
      bus_if.EN = 1'b0;
      rises     = 0;
      repeat (5000) begin
         @(negedge CLK);
         if (bus_if.BUSY || !dht_data) rises++;
      end
      check("poll_stopped", 64'(rises), 64'd0);
`else
      // Good frame with a 0x37/0x19/0x05 payload and a stray START mid-frame.
      run_frame(40'h37_00_19_05_55, 1'b1);
      check("good_hum_int",  64'(bus_if.HUM_INT),    64'h37);
      check("good_temp_int", 64'(bus_if.TEMP_INT),   64'h19);
      check("good_temp_fl",  64'(bus_if.TEMP_FLOAT), 64'h05);
      check("good_crc",      64'(bus_if.CRC),        64'h55);
      check("good_err",      64'(bus_if.ERR),        64'd0);
      check("good_valid_n",  64'(valid_count),       64'd1);

      run_frame(40'h37_00_19_05_56, 1'b0);
      check("crc_err",       64'(bus_if.ERR),      64'd2);
      check("crc_valid_n",   64'(valid_count),     64'd1);
      check("crc_hum_int",   64'(bus_if.HUM_INT),  64'h37);
      check("crc_temp_int",  64'(bus_if.TEMP_INT), 64'h19);

      // No sensor: measure the start pulse and the timeout in clocks (2 per us).
      sensor_present = 1'b0;
      wait_sensor_idle();
      pulse_start();
      n_low = 0;
      while (dht_data == 1'b0 && n_low < 1000) begin
         n_low++;
         @(negedge CLK);
      end
      check_range("start_low_clks", n_low, 200, 204);
      n_rel = 0;
      while (bus_if.BUSY && n_rel < 1000) begin
         n_rel++;
         @(negedge CLK);
      end
      check_range("timeout_clks", n_rel, 400, 404);
      check("timeout_err",  64'(bus_if.ERR),     64'd1);
      check("timeout_busy", 64'(bus_if.BUSY),    64'd0);
      check("timeout_hold", 64'(bus_if.HUM_INT), 64'h37);

      // EN low during the host pulse releases the bus next cycle and keeps status.
      pulse_start();
      repeat (60) @(negedge CLK);
      check("en_busy_before", 64'(bus_if.BUSY), 64'd1);
      check("en_bus_before",  64'(dht_data),    64'd0);
      bus_if.EN = 1'b0;
      @(negedge CLK);
      check("en_busy_after", 64'(bus_if.BUSY), 64'd0);
      check("en_bus_after",  64'(dht_data),    64'd1);
      check("en_err_kept",   64'(bus_if.ERR),  64'd1);
      bus_if.EN = 1'b1;
      repeat (4) @(negedge CLK);

      run_frame(40'h41_02_1A_08_65, 1'b0);
      check_bytes(40'h41_02_1A_08_65);
      check("good2_err",     64'(bus_if.ERR),  64'd0);
      check("good2_valid_n", 64'(valid_count), 64'd2);

      // Reset while the sensor is in the high phase of bit 20.
      tx_frame       = 40'h50_01_20_03_74;
      sensor_present = 1'b1;
      wait_sensor_idle();
      pulse_start();
      n = 0;
      while (!(sensor_bit == 20 && sensor_high) && n < 10000) begin
         @(negedge CLK);
         n++;
      end
      check("reached_bit20", 64'(sensor_bit), 64'd20);
      RST           = 1'b1;
      pending_valid = 1'b0;
      committed     = '0;
      @(negedge CLK);
      check_bytes(40'h0);
      check("rst_busy",  64'(bus_if.BUSY),  64'd0);
      check("rst_err",   64'(bus_if.ERR),   64'd0);
      check("rst_valid", 64'(bus_if.VALID), 64'd0);
      check("rst_bus",   64'(dht_data),     64'd1);
      RST = 1'b0;
      run_frame(40'h50_01_20_03_74, 1'b0);
      check_bytes(40'h50_01_20_03_74);
      check("rst_next_err",     64'(bus_if.ERR),  64'd0);
      check("rst_next_valid_n", 64'(valid_count), 64'd3);

      // Without START nothing happens.
      rises = 0;
      repeat (4400) begin
         @(negedge CLK);
         if (bus_if.BUSY) rises++;
      end
      check("no_spontaneous", 64'(rises), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
